// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared handshake codes, zero word and divider state encodings
package div_iter_pkg;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [1:0] DIV_FREE = 2'b00;
  localparam logic [1:0] DIV_BYZERO = 2'b01;
  localparam logic [1:0] DIV_ON = 2'b10;
  localparam logic [1:0] DIV_END = 2'b11;
endpackage

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider answering the EX divide handshake
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  logic [1:0] r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_rem, r_quo, r_dvs;
  logic r_neg_q, r_neg_r;
  logic w_neg1, w_neg2, w_borrow, w_last, w_abort;
  logic [DATA_W-1:0] w_abs1, w_abs2, w_diff, w_rem_nx, w_quo_nx, w_q_fix, w_r_fix;
  logic [DATA_W:0] w_shift;
  // operand magnitudes and one restoring step; w_shift carries the extra bit for the borrow
  always_comb begin
    w_neg1 = signed_div_i & opdata1_i[DATA_W-1];
    w_neg2 = signed_div_i & opdata2_i[DATA_W-1];
    w_abs1 = w_neg1 ? -opdata1_i : opdata1_i;
    w_abs2 = w_neg2 ? -opdata2_i : opdata2_i;
    w_shift = {r_rem, r_quo[DATA_W-1]};
    w_borrow = w_shift < {1'b0, r_dvs};
    w_diff = w_shift[DATA_W-1:0] - r_dvs;
    w_rem_nx = w_borrow ? w_shift[DATA_W-1:0] : w_diff;
    w_quo_nx = {r_quo[DATA_W-2:0], ~w_borrow};
    w_q_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    w_r_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_last = r_cnt == CNT_W'(DATA_W - 1);
    w_abort = annul_i | (start_i == DIV_STOP);
  end
  // handshake FSM and iterative datapath; outputs only change here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_FREE;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      ready_o <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      case (r_state)
        DIV_FREE: begin
          ready_o <= DIV_RESULT_NOT_READY;
          result_o <= '0;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) r_state <= DIV_BYZERO;
            else begin
              r_state <= DIV_ON;
              r_cnt <= '0;
              r_rem <= '0;
              r_quo <= w_abs1;
              r_dvs <= w_abs2;
              r_neg_q <= w_neg1 ^ w_neg2;
              r_neg_r <= w_neg1;
            end
          end
        end
        DIV_BYZERO: begin
          if (w_abort) r_state <= DIV_FREE;
          else begin
            r_state <= DIV_END;
            ready_o <= DIV_RESULT_READY;
            result_o <= '0;
          end
        end
        DIV_ON: begin
          if (w_abort) r_state <= DIV_FREE;
          else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DIV_END;
              ready_o <= DIV_RESULT_READY;
              result_o <= {w_r_fix, w_q_fix};
            end
          end
        end
        default: begin
          if (start_i == DIV_STOP) begin
            r_state <= DIV_FREE;
            ready_o <= DIV_RESULT_NOT_READY;
            result_o <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed divides with a result scoreboard and handshake timing checks
module tb_div_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  int total = 0;
  int bad = 0;
  logic [63:0] q_exp[$];
  logic prev_ready = 1'b0;

  div_iter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // monitor: every rising ready_o must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && ready_o && !prev_ready) begin
      total++;
      if (q_exp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: got %h want no result", result_o);
      end else begin
        logic [63:0] e;
        e = q_exp.pop_front();
        if (result_o !== e) begin
          bad++;
          $display("FAIL result: got %h want %h", result_o, e);
        end
      end
    end
    prev_ready <= rst ? 1'b0 : ready_o;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // issue one divide, check latency, hold start for `hold` ready cycles, then release
  task automatic do_div(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input int hold);
    int n;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    q_exp.push_back(exp);
    n = 0;
    do begin
      step(1);
      n++;
      if (n == 2) begin
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0000_0001;
        signed_div_i = ~s;
      end
    end while (!ready_o && n < 100);
    check({name, "_latency"}, 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      step(1);
      check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({name, "_hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    step(1);
    check({name, "_release_ready"}, 64'(ready_o), 64'd0);
    check({name, "_release_result"}, result_o, 64'd0);
  endtask

  initial begin
    step(3);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    step(1);
    check("idle_ready", 64'(ready_o), 64'd0);
    do_div("u_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33, 0);
    do_div("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 0);
    do_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 33, 0);
    do_div("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 64'h00000002_FFFFFFF2, 33, 0);
    do_div("byzero", 1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
    // annul after ten iterations; start released together so nothing restarts
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    step(11);
    annul_i = 1'b1;
    start_i = 1'b0;
    step(1);
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        step(1);
        if (ready_o) seen++;
      end
      check("annul_never_ready", 64'(seen), 64'd0);
    end
    do_div("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);
    do_div("hold5", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 5);
    do_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 33, 0);
    // reset after fifteen iterations discards the operation
    opdata1_i = 32'd1234;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    step(16);
    rst = 1'b1;
    start_i = 1'b0;
    step(1);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    step(1);
    do_div("u_8_2", 1'b0, 32'd8, 32'd2, 64'h00000000_00000004, 33, 0);
    step(3);
    check("queue_empty", 64'(q_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; the responder side of the EX divide handshake.
- EX drives operands, sign mode and start, and holds them while it stalls the pipeline.
- The divider runs radix-2 restoring shift-subtract, then presents {remainder, quotient} with ready until EX releases start.
- HI/LO writeback takes result_o[63:32] as HI and result_o[31:0] as LO.

Parameters:
- DATA_W, 32, operand width; latency and result width scale with it (result 2*DATA_W).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- signed_div_i  in  1  1 = signed (div), 0 = unsigned (divu); sampled only when accepted
- opdata1_i  in  DATA_W  dividend; sampled only when accepted
- opdata2_i  in  DATA_W  divisor; sampled only when accepted
- start_i  in  1  request; DivStart = 1, DivStop = 0; held high by initiator until ready seen
- annul_i  in  1  abort in-flight operation
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o = 1
- ready_o  out  1  DivResultReady = 1, DivResultNotReady = 0

Behaviour:
- States: FREE, BYZERO, ON, END (2-bit encoding). Reset (rst = 1 at an edge) forces FREE, ready_o = 0, result_o = 0, count = 0. Reset mid-operation discards all work.
- FREE:
  - On start_i = 1 and annul_i = 0, the edge (call it E0) latches sign mode and the operands.
  - Divisor == 0 → BYZERO.
  - Otherwise → ON with count = 0. For signed mode, latches |dividend| and |divisor| (two's-complement negate when MSB = 1) plus both sign bits.
- BYZERO: next edge → END with result_o = 0. ready_o is high in the cycle after E1.
- ON:
  - Each edge performs one iteration: shift partial remainder left 1, bring in next dividend MSB, trial-subtract divisor. If non-negative, keep the difference and set the quotient bit to 1; else restore and set the bit to 0.
  - count increments each iteration. On the edge completing iteration DATA_W (E32) → END.
  - On that same edge, result_o is registered with sign fix-up (below), and ready_o goes high.
  - ready_o is first high in the cycle after E32, i.e. 33 cycles after start was accepted.
- Abort: in ON or BYZERO, annul_i = 1 or start_i = 0 at an edge → FREE next edge, ready_o = 0, result_o = 0, no result produced. annul_i takes priority over any transition.
- END:
  - ready_o = 1 and result_o held stable while start_i = 1; no restart from END.
  - start_i = 0 at an edge → FREE, ready_o = 0, result_o = 0.
  - The initiator drops start in the first ready cycle, so a back-to-back divide can reassert start the following cycle and is accepted (FREE) with no dead cycle beyond that.
- Sign fix-up (signed mode only):
  - Quotient is negated iff dividend sign != divisor sign.
  - Remainder is negated iff dividend is negative.
  - Unsigned mode: no fix-up.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0 (wraps, no trap).
- Operand changes after acceptance are ignored.
- annul_i in FREE or END has no effect beyond the rules above.
- Partial-remainder datapath is DATA_W+1 bits wide to hold the borrow.
- Outputs are registered only; no combinational path from inputs to ready_o or result_o.

Decomposition:
- Shared defines (the existing global defines header): DivStart, DivStop, DivResultReady, DivResultNotReady, ZeroWord, and the state codes DivFree, DivByZero, DivOn, DivEnd.
- No sub-module. A single always block for the FSM and datapath, plus small combinational negate/abs helpers, is sufficient (~150-200 lines).

Test Plan:
- Unsigned: 100 / 7, start held high → ready_o rises exactly 33 cycles after acceptance; result_o = 0x00000002_0000000E.
- Signed and wrap:
  - -7 / 2 → result_o = 0xFFFFFFFF_FFFFFFFD.
  - 0x80000000 / 0xFFFFFFFF signed → 0x00000000_80000000.
  - 0xFFFFFFFF / 0x10 unsigned → 0x0000000F_0FFFFFFF.
- Divide by zero: 5 / 0 → ready_o high 2 cycles after acceptance; result_o = 0; start_i dropped → ready_o = 0 next cycle.
- Annul: start 1000 / 3, pulse annul_i at iteration 10 → FREE, ready_o never rises. Then 9 / 3 → result_o = 0x00000000_00000003 after 33 cycles.
- Handshake hold and back-to-back:
  - Keep start_i high 5 cycles in END → ready_o and result_o stable.
  - Drop start_i → ready_o low next cycle.
  - Reassert start the next cycle with 20 / 6 → accepted; result 0x00000002_00000003.
- Reset mid-operation: rst at iteration 15 → next cycle ready_o = 0, result_o = 0, FREE. A subsequent 8 / 2 completes normally with quotient 4.
